// File: rtl/lc3_mem_access_ctrl.sv
// LC-3 memory access initiator: owns MAR/MDR and sequences a fixed-latency
// memory access, returning a one-cycle ready (R) pulse on completion.
module lc3_mem_access_ctrl #(
   parameter int unsigned ADDR_SIZE = 16,
   parameter int unsigned DATA_SIZE = 16,
   parameter int unsigned LATENCY   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_SIZE-1:0] bus_in,
   input  logic                 ld_mar,
   input  logic                 ld_mdr,
   input  logic                 mio_en,
   input  logic                 r_w,
   input  logic [DATA_SIZE-1:0] mem_rdata,
   output logic [ADDR_SIZE-1:0] mem_addr,
   output logic [DATA_SIZE-1:0] mem_wdata,
   output logic                 mem_en,
   output logic                 mem_ctrl,
   output logic [ADDR_SIZE-1:0] mar_out,
   output logic [DATA_SIZE-1:0] mdr_out,
   output logic                 ready
);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e               state_q, state_d;
   logic [ADDR_SIZE-1:0] mar_q, mar_d;
   logic [DATA_SIZE-1:0] mdr_q, mdr_d;
   logic [ADDR_SIZE-1:0] addr_q, addr_d;
   logic [DATA_SIZE-1:0] wdata_q, wdata_d;
   logic                 en_q, en_d;
   logic                 ctrl_q, ctrl_d;
   logic                 ready_q, ready_d;
   logic [3:0]           cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      mar_d   = mar_q;
      mdr_d   = mdr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      en_d    = en_q;
      ctrl_d  = ctrl_q;
      ready_d = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (ld_mar) mar_d = bus_in[ADDR_SIZE-1:0];
            if (ld_mdr) mdr_d = bus_in;
            // Access launches from the pre-edge MAR/MDR, not same-edge loads.
            if (mio_en) begin
               addr_d  = mar_q;
               wdata_d = mdr_q;
               ctrl_d  = r_w;
               en_d    = 1'b1;
               cnt_d   = 4'(LATENCY - 1);
               state_d = StAccess;
            end
         end
         StAccess: begin
            if (!mio_en) begin
               en_d    = 1'b0;
               ctrl_d  = 1'b0;
               state_d = StIdle;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (!ctrl_q) mdr_d = mem_rdata;
               en_d    = 1'b0;
               ctrl_d  = 1'b0;
               ready_d = 1'b1;
               state_d = StDone;
            end
         end
         StDone: begin
            if (ld_mar) mar_d = bus_in[ADDR_SIZE-1:0];
            if (ld_mdr) mdr_d = bus_in;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         mar_q   <= '0;
         mdr_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         en_q    <= 1'b0;
         ctrl_q  <= 1'b0;
         ready_q <= 1'b0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         en_q    <= en_d;
         ctrl_q  <= ctrl_d;
         ready_q <= ready_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_en    = en_q;
   assign mem_ctrl  = ctrl_q;
   assign mar_out   = mar_q;
   assign mdr_out   = mdr_q;
   assign ready     = ready_q;

endmodule

// File: tb/tb_lc3_mem_access_ctrl.sv
// Directed bench for lc3_mem_access_ctrl: LATENCY=4 instance for the main
// scenarios, LATENCY=1 instance for back-to-back accesses.
module tb_lc3_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] bus_in, mem_rdata, mem_addr, mem_wdata, mar_out, mdr_out;
   logic        ld_mar, ld_mdr, mio_en, r_w, mem_en, mem_ctrl, ready;

   logic [15:0] b_bus_in, b_mem_rdata, b_mem_addr, b_mem_wdata, b_mar_out, b_mdr_out;
   logic        b_ld_mar, b_ld_mdr, b_mio_en, b_r_w, b_mem_en, b_mem_ctrl, b_ready;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   // Memory model: address 5 holds BEEF, everything else DEAD.
   assign mem_rdata   = (mem_addr == 16'h0005) ? 16'hBEEF : 16'hDEAD;
   assign b_mem_rdata = 16'h0000;

   lc3_mem_access_ctrl #(.ADDR_SIZE(16), .DATA_SIZE(16), .LATENCY(4)) dut (
      .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
      .mio_en(mio_en), .r_w(r_w), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_ctrl(mem_ctrl), .mar_out(mar_out),
      .mdr_out(mdr_out), .ready(ready)
   );

   lc3_mem_access_ctrl #(.ADDR_SIZE(16), .DATA_SIZE(16), .LATENCY(1)) dut_b2b (
      .clk(clk), .rst_n(rst_n), .bus_in(b_bus_in), .ld_mar(b_ld_mar), .ld_mdr(b_ld_mdr),
      .mio_en(b_mio_en), .r_w(b_r_w), .mem_rdata(b_mem_rdata), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_en(b_mem_en), .mem_ctrl(b_mem_ctrl),
      .mar_out(b_mar_out), .mdr_out(b_mdr_out), .ready(b_ready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus_in = '0; ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0;
      b_bus_in = '0; b_ld_mar = 0; b_ld_mdr = 0; b_mio_en = 0; b_r_w = 0;
      tick(); tick();
      n_checks++;
      if ({mem_addr, mem_wdata, mem_en, mem_ctrl, mar_out, mdr_out, ready} !== 67'd0)
         $display("FAIL reset_outputs: got addr=%h wdata=%h en=%b ctrl=%b mar=%h mdr=%h rdy=%b, want all 0",
                  mem_addr, mem_wdata, mem_en, mem_ctrl, mar_out, mdr_out, ready);
      else n_pass++;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if ({ready, mem_en, b_ready, b_mem_en} !== 4'b0000)
            $display("FAIL idle_quiet[%0d]: got rdy=%b en=%b b_rdy=%b b_en=%b, want 0000",
                     i, ready, mem_en, b_ready, b_mem_en);
         else n_pass++;
      end
   endtask

   task automatic test_write();
      bus_in = 16'h0005; ld_mar = 1; tick();
      ld_mar = 0; bus_in = 16'hBEEF; ld_mdr = 1; tick();
      ld_mdr = 0;
      n_checks++;
      if ({mar_out, mdr_out} !== {16'h0005, 16'hBEEF})
         $display("FAIL write_regs: got mar=%h mdr=%h, want 0005 BEEF", mar_out, mdr_out);
      else n_pass++;
      mio_en = 1; r_w = 1; tick();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if ({mem_en, mem_ctrl, mem_addr, mem_wdata, ready} !== {2'b11, 16'h0005, 16'hBEEF, 1'b0})
            $display("FAIL write_access[%0d]: got en=%b ctrl=%b addr=%h wdata=%h rdy=%b, want 1 1 0005 BEEF 0",
                     i, mem_en, mem_ctrl, mem_addr, mem_wdata, ready);
         else n_pass++;
         tick();
      end
      n_checks++;
      if ({mem_en, mem_ctrl, ready} !== 3'b001)
         $display("FAIL write_ready: got en=%b ctrl=%b rdy=%b, want 0 0 1", mem_en, mem_ctrl, ready);
      else n_pass++;
      mio_en = 0; tick();
      n_checks++;
      if (ready !== 1'b0) $display("FAIL write_ready_pulse: got rdy=%b, want 0", ready);
      else n_pass++;
   endtask

   task automatic test_read();
      bus_in = 16'h0000; ld_mdr = 1; tick();
      ld_mdr = 0;
      mio_en = 1; r_w = 0; tick();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if ({mem_en, mem_ctrl, mem_addr, ready, mdr_out} !== {2'b10, 16'h0005, 1'b0, 16'h0000})
            $display("FAIL read_access[%0d]: got en=%b ctrl=%b addr=%h rdy=%b mdr=%h, want 1 0 0005 0 0000",
                     i, mem_en, mem_ctrl, mem_addr, ready, mdr_out);
         else n_pass++;
         tick();
      end
      n_checks++;
      if ({mem_en, ready, mdr_out} !== {2'b01, 16'hBEEF})
         $display("FAIL read_ready: got en=%b rdy=%b mdr=%h, want 0 1 BEEF", mem_en, ready, mdr_out);
      else n_pass++;
      mio_en = 0; tick();
   endtask

   task automatic test_ignored_loads();
      mio_en = 1; r_w = 1; tick();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if ({mem_en, mem_ctrl, mem_addr, mem_wdata} !== {2'b11, 16'h0005, 16'hBEEF})
            $display("FAIL ignore_hold[%0d]: got en=%b ctrl=%b addr=%h wdata=%h, want 1 1 0005 BEEF",
                     i, mem_en, mem_ctrl, mem_addr, mem_wdata);
         else n_pass++;
         if (i == 0) begin ld_mar = 1; bus_in = 16'h0007; r_w = 0; end
         if (i == 1) begin ld_mar = 0; ld_mdr = 1; bus_in = 16'h1234; end
         if (i == 2) begin ld_mdr = 0; r_w = 1; end
         tick();
      end
      n_checks++;
      if ({ready, mar_out, mdr_out} !== {1'b1, 16'h0005, 16'hBEEF})
         $display("FAIL ignore_after: got rdy=%b mar=%h mdr=%h, want 1 0005 BEEF",
                  ready, mar_out, mdr_out);
      else n_pass++;
      mio_en = 0; tick();
   endtask

   task automatic test_abort();
      bus_in = 16'h1111; ld_mdr = 1; tick();
      ld_mdr = 0;
      mio_en = 1; r_w = 0; tick();
      tick();
      mio_en = 0; tick();
      n_checks++;
      if ({mem_en, mem_ctrl} !== 2'b00)
         $display("FAIL abort_en: got en=%b ctrl=%b, want 0 0", mem_en, mem_ctrl);
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if ({ready, mem_en, mdr_out} !== {2'b00, 16'h1111})
            $display("FAIL abort_quiet[%0d]: got rdy=%b en=%b mdr=%h, want 0 0 1111",
                     i, ready, mem_en, mdr_out);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_async_reset();
      mio_en = 1; r_w = 0; tick(); tick();
      n_checks++;
      if (mem_en !== 1'b1) $display("FAIL rst_pre: got en=%b, want 1", mem_en);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({mem_addr, mem_wdata, mem_en, mem_ctrl, mar_out, mdr_out, ready} !== 67'd0)
         $display("FAIL rst_async: got addr=%h wdata=%h en=%b ctrl=%b mar=%h mdr=%h rdy=%b, want all 0",
                  mem_addr, mem_wdata, mem_en, mem_ctrl, mar_out, mdr_out, ready);
      else n_pass++;
      mio_en = 0; tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++;
         if ({ready, mdr_out} !== 17'd0)
            $display("FAIL rst_after[%0d]: got rdy=%b mdr=%h, want 0 0000", i, ready, mdr_out);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] addrs [4];
      addrs[0] = 16'h0010; addrs[1] = 16'h0020; addrs[2] = 16'h0030; addrs[3] = 16'h0040;
      b_bus_in = addrs[0]; b_ld_mar = 1; tick();
      b_ld_mar = 0;
      b_mio_en = 1; b_r_w = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if ({b_mem_en, b_ready, b_mem_addr} !== {2'b10, addrs[k]})
            $display("FAIL b2b_access[%0d]: got en=%b rdy=%b addr=%h, want 1 0 %h",
                     k, b_mem_en, b_ready, b_mem_addr, addrs[k]);
         else n_pass++;
         tick();
         n_checks++;
         if ({b_mem_en, b_ready} !== 2'b01)
            $display("FAIL b2b_ready[%0d]: got en=%b rdy=%b, want 0 1", k, b_mem_en, b_ready);
         else n_pass++;
         b_bus_in = addrs[k+1]; b_ld_mar = 1;
         tick();
         b_ld_mar = 0;
         n_checks++;
         if ({b_mem_en, b_ready, b_mar_out} !== {2'b00, addrs[k+1]})
            $display("FAIL b2b_idle[%0d]: got en=%b rdy=%b mar=%h, want 0 0 %h",
                     k, b_mem_en, b_ready, b_mar_out, addrs[k+1]);
         else n_pass++;
      end
      b_mio_en = 0; tick();
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_ignored_loads();
      test_abort();
      test_async_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lc3_mem_access_ctrl.md
Name: lc3_mem_access_ctrl

Overview:
- Initiator side of the LC-3 memory interface: holds the MAR and MDR registers and drives the memory's enable, read/write control, address and write data.
- Runs a multi-cycle access and returns the LC-3 ready signal R to the control FSM.
- Sits between the processor bus, datapath control signals (LD.MAR, LD.MDR, MIO.EN, R.W) and the memory array's in/addr/en/ctrl/out port.

Parameters:
- ADDR_SIZE, 16, address width (MAR width)
- DATA_SIZE, 16, data width (MDR, bus and memory data width)
- LATENCY, 4, cycles mem_en is held per access; legal range 1..15

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- bus_in  input  DATA_SIZE  processor bus, source for MAR/MDR loads
- ld_mar  input  1  load MAR from bus_in[ADDR_SIZE-1:0]
- ld_mdr  input  1  load MDR from bus_in (processor-side load)
- mio_en  input  1  request memory access; held high by FSM until ready
- r_w  input  1  0 = read, 1 = write; sampled at access start
- mem_rdata  input  DATA_SIZE  memory data out
- mem_addr  output  ADDR_SIZE  address to memory
- mem_wdata  output  DATA_SIZE  write data to memory
- mem_en  output  1  memory enable
- mem_ctrl  output  1  memory control: 0 = read, 1 = write
- mar_out  output  ADDR_SIZE  current MAR value
- mdr_out  output  DATA_SIZE  current MDR value (drives GateMDR path)
- ready  output  1  LC-3 R signal; one-cycle pulse at access completion

Behaviour:
- Reset (rst_n low, asynchronous): MAR=0, MDR=0, mem_addr=0, mem_wdata=0, mem_en=0, mem_ctrl=0, ready=0, state=IDLE, counter=0. Reset asserted mid-access aborts it immediately; MDR is not updated and no ready is produced.
- All outputs are registered. The FSM has three states: IDLE, ACCESS, DONE.
- IDLE:
  - ld_mar=1 -> MAR <= bus_in at the edge.
  - ld_mdr=1 -> MDR <= bus_in at the edge.
  - If mio_en=1 at the edge:
    - mem_addr <= MAR (before any same-edge ld_mar update). Same-edge ld_mar still updates MAR, but the access uses the old MAR.
    - mem_wdata <= MDR (old value, same rule).
    - mem_ctrl <= r_w, mem_en <= 1, counter <= LATENCY-1, go to ACCESS.
- ACCESS:
  - mem_en, mem_addr, mem_ctrl and mem_wdata are held constant.
  - ld_mar, ld_mdr and r_w changes are ignored.
  - If counter != 0, decrement it.
  - If counter == 0:
    - Read: MDR <= mem_rdata.
    - Both cases: mem_en <= 0, mem_ctrl <= 0, go to DONE.
  - If mio_en drops in ACCESS: abort. mem_en <= 0, mem_ctrl <= 0, go to IDLE, no MDR update, no ready.
- DONE: ready=1 for exactly this one cycle, then IDLE.
  - ld_mar and ld_mdr are honoured in DONE as in IDLE.
  - ld_mdr in DONE overrides nothing, because the MDR read capture happened on the previous edge.
  - A new access cannot start from DONE. If mio_en is still high in the IDLE cycle that follows, a new access starts at that edge (back-to-back access is allowed).
- Timing: if mio_en is sampled at edge E0, mem_en is high for exactly LATENCY cycles starting after E0, and ready is high during cycle LATENCY+1 after E0. For a read, mdr_out holds the new data in the same cycle ready is high.
- mar_out and mdr_out always reflect the MAR and MDR registers.
- No address wrap logic is needed; MAR is the full ADDR_SIZE width.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then release -> all outputs 0, ready never pulses with mio_en=0.
- Write: bus_in=16'h0005 with ld_mar, then bus_in=16'hBEEF with ld_mdr, then mio_en=1, r_w=1 until ready -> mem_en=1, mem_ctrl=1, mem_addr=5, mem_wdata=BEEF for exactly 4 cycles; ready pulses 1 cycle in the 5th cycle after the request edge.
- Read: MAR=5, memory model returns BEEF at addr 5, mio_en=1, r_w=0 -> mem_ctrl=0 for 4 cycles; mdr_out=BEEF while ready=1.
- Ignored mid-access loads: during an ACCESS to addr 5, pulse ld_mar with bus_in=7 and ld_mdr with bus_in=1234 -> mem_addr stays 5 and mem_wdata stays at its start value for the whole access; MAR=5 after completion (load ignored).
- Abort: drop mio_en in the 2nd ACCESS cycle -> mem_en low on the next cycle, ready never asserts, MDR unchanged. Separately, assert rst_n low mid-read -> outputs clear immediately (asynchronously).
- Back-to-back with LATENCY=1: mio_en held high continuously -> pattern repeats mem_en 1 cycle, ready 1 cycle, 1 idle cycle, with every access using the current MAR.
